spi_frame_collector: RTL and testbench
======================================

SPI_FRAME_COLLECTOR -- requirements
Module: spi_frame_collector

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each SPI pad input (min 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports spi_csn, spi_sck, spi_mosi, spi_miso  input  1 each  raw SPI bus, asynchronous to clk; clk at least 4x sck.
REQ-005 SHALL have ports cfg_cmd_len  input  6  command bits per frame; cfg_addr_len  input  6  address bits; cfg_data_len  input  16  data bits.
REQ-006 SHALL have ports pkt_valid  output  1  and pkt_ready  input  1  output packet handshake.
REQ-007 SHALL have ports pkt_spi_length  output  32  total sampled sck edges in frame; pkt_cmd, pkt_addr, pkt_mosi_data, pkt_miso_data  output  32 each.
REQ-008 SHALL have ports pkt_flag  output  2  (bit0 truncated, bit1 overlength); drop_count  output  8  frames dropped on backpressure.

Function
REQ-009 SHALL synchronize each SPI input through SYNC_STAGES flops; csn stages reset to 1, others to 0.
REQ-010 SHALL detect a sample event on a synchronized sck 0->1 transition while synchronized csn is 0 (SPI mode 0, MSB first).
REQ-011 SHALL use states IDLE, CMD, ADDR, DATA, DONE; reset state IDLE.
REQ-012 SHALL, on synchronized csn 1->0 in IDLE, latch cfg lengths, clear all field shift registers and counters, and enter CMD, or ADDR if cmd_len=0, or DATA if cmd_len=addr_len=0, or DONE if all three are 0.
REQ-013 SHALL treat cmd_len/addr_len values above 32 as 32.
REQ-014 SHALL shift mosi into the current field on each sample event and increment the 32-bit bit counter (saturating at 0xFFFF_FFFF).
REQ-015 SHALL advance CMD->ADDR->DATA->DONE on the sample event that completes the field length, skipping zero-length fields.
REQ-016 SHALL shift miso into the miso field only in DATA; data fields longer than 32 bits keep the last 32 bits received.
REQ-017 SHALL, on sample events in DONE, increment the bit counter only and set overlength flag.
REQ-018 SHALL, on synchronized csn 0->1, end the frame: set truncated flag if state is not DONE; return to IDLE.
REQ-019 SHALL discard a frame with bit counter 0 (no packet, no drop count).
REQ-020 SHALL assert pkt_valid in the clock cycle after csn 0->1 detection and hold all pkt_* stable until the cycle pkt_valid and pkt_ready are both 1.
REQ-021 SHALL, if a frame ends while pkt_valid=1 and pkt_ready=0, drop the new frame, keep the held packet, and increment drop_count, saturating at 255.
REQ-022 SHALL accept a completing handshake and a new frame end in the same cycle: the new packet is loaded and pkt_valid stays 1, no drop.
REQ-023 SHALL begin a new frame capture while a previous packet awaits handshake.

Reset
REQ-024 SHALL, while rstn=0, drive pkt_valid=0, all pkt_* fields 0, drop_count=0, state IDLE.
REQ-025 SHALL, if rstn releases with csn low, ignore the bus until synchronized csn has been seen high then low.
REQ-026 SHALL abandon any partial frame on reset with no packet emitted.

Verification
REQ-027 SHALL be checked: lengths 8/24/32, cmd=0x0B, addr=0x00_1234, mosi=0xDEAD_BEEF, miso=0xCAFE_F00D -> one packet, spi_length=64, fields match, flag=00.
REQ-028 SHALL be checked: lengths 8/0/0, cmd 0x9F, csn high after 5 bits -> spi_length=5, pkt_cmd=0x13, flag=01.
REQ-029 SHALL be checked: lengths 0/0/16, 20 edges mosi=0xABCD then 0xF -> pkt_mosi_data=0xABCD, spi_length=20, flag=10.
REQ-030 SHALL be checked: pkt_ready held 0 across three complete frames -> first packet retained, drop_count=2; pkt_ready=1 -> handshake, pkt_valid=0.
REQ-031 SHALL be checked: rstn pulsed low mid-DATA with csn low, csn later high then a clean frame -> no packet for aborted frame, clean frame captured exactly.
REQ-032 SHALL be checked: csn toggled low then high with no sck edges -> no packet, drop_count unchanged.

Source files
------------

// File: rtl/spi_frame_collector_if.sv
// spi_frame_collector_if: raw SPI pads, frame-length config and the packet handshake of the frame collector.
// The master modport is the collector itself; the slave modport is the SPI driver and packet consumer.
interface spi_frame_collector_if;
    logic        spi_csn;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic [5:0]  cfg_cmd_len;
    logic [5:0]  cfg_addr_len;
    logic [15:0] cfg_data_len;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_spi_length;
    logic [31:0] pkt_cmd;
    logic [31:0] pkt_addr;
    logic [31:0] pkt_mosi_data;
    logic [31:0] pkt_miso_data;
    logic [1:0]  pkt_flag;
    logic [7:0]  drop_count;

    modport master (
        input  spi_csn, spi_sck, spi_mosi, spi_miso,
        input  cfg_cmd_len, cfg_addr_len, cfg_data_len,
        input  pkt_ready,
        output pkt_valid, pkt_spi_length, pkt_cmd, pkt_addr,
        output pkt_mosi_data, pkt_miso_data, pkt_flag, drop_count
    );

    modport slave (
        output spi_csn, spi_sck, spi_mosi, spi_miso,
        output cfg_cmd_len, cfg_addr_len, cfg_data_len,
        output pkt_ready,
        input  pkt_valid, pkt_spi_length, pkt_cmd, pkt_addr,
        input  pkt_mosi_data, pkt_miso_data, pkt_flag, drop_count
    );
endinterface

// File: rtl/spi_frame_collector.sv
// spi_frame_collector: oversamples a mode-0 SPI frame into cmd/addr/data fields and
// presents it as a packet held until handshake; frames ending during backpressure are dropped.
module spi_frame_collector #(
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   rstn,
    spi_frame_collector_if.master bus
);
    localparam int M = SYNC_STAGES - 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    state_t      state, state_nx, first, after_cmd, after_addr;
    logic [M:0]  csn_sy, sck_sy, mosi_sy, miso_sy, fill;
    logic        csn_q, sck_q, armed;
    logic        csn_s, sck_s, mosi_s, miso_s;
    logic        csn_fall, csn_rise, sample, last, load;
    logic [5:0]  cl_in, al_in, cmd_len, addr_len;
    logic [15:0] data_len, fld_cnt;
    logic [16:0] fld_nx, cur_len;
    logic [31:0] cmd_sr, addr_sr, mosi_sr, miso_sr, bit_cnt;
    logic        ovl;
    logic        pv;
    logic [31:0] p_len, p_cmd, p_addr, p_mosi, p_miso;
    logic [1:0]  p_flag;
    logic [7:0]  drops;

    // fill marks when the csn chain holds a real pad value rather than its reset preset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csn_sy  <= '1;
            sck_sy  <= '0;
            mosi_sy <= '0;
            miso_sy <= '0;
            fill    <= '0;
            csn_q   <= 1'b1;
            sck_q   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            csn_sy  <= {csn_sy[M-1:0], bus.spi_csn};
            sck_sy  <= {sck_sy[M-1:0], bus.spi_sck};
            mosi_sy <= {mosi_sy[M-1:0], bus.spi_mosi};
            miso_sy <= {miso_sy[M-1:0], bus.spi_miso};
            fill    <= {fill[M-1:0], 1'b1};
            csn_q   <= csn_s;
            sck_q   <= sck_s;
            armed   <= armed | (fill[M] & csn_s);
        end
    end

    assign csn_s    = csn_sy[M];
    assign sck_s    = sck_sy[M];
    assign mosi_s   = mosi_sy[M];
    assign miso_s   = miso_sy[M];
    assign csn_fall = armed & csn_q & ~csn_s;
    assign csn_rise = ~csn_q & csn_s;
    assign sample   = sck_s & ~sck_q & ~csn_s;

    assign cl_in      = bus.cfg_cmd_len > 6'd32 ? 6'd32 : bus.cfg_cmd_len;
    assign al_in      = bus.cfg_addr_len > 6'd32 ? 6'd32 : bus.cfg_addr_len;
    assign first      = cl_in != 6'd0 ? CMD : al_in != 6'd0 ? ADDR : bus.cfg_data_len != 16'd0 ? DATA : DONE;
    assign after_addr = data_len != 16'd0 ? DATA : DONE;
    assign after_cmd  = addr_len != 6'd0 ? ADDR : after_addr;
    assign cur_len    = state == CMD ? {11'd0, cmd_len} : state == ADDR ? {11'd0, addr_len} : {1'b0, data_len};
    assign fld_nx     = {1'b0, fld_cnt} + 17'd1;
    assign last       = (state == CMD || state == ADDR || state == DATA) && fld_nx == cur_len;
    assign load       = state != IDLE && csn_rise && bit_cnt != 32'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = csn_fall ? first : IDLE;
        else if (csn_rise) state_nx = IDLE;
        else if (sample && last) state_nx = state == CMD ? after_cmd : state == ADDR ? after_addr : DONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_len  <= '0;
            addr_len <= '0;
            data_len <= '0;
            fld_cnt  <= '0;
            cmd_sr   <= '0;
            addr_sr  <= '0;
            mosi_sr  <= '0;
            miso_sr  <= '0;
            bit_cnt  <= '0;
            ovl      <= 1'b0;
        end else if (state == IDLE && csn_fall) begin
            cmd_len  <= cl_in;
            addr_len <= al_in;
            data_len <= bus.cfg_data_len;
            fld_cnt  <= '0;
            cmd_sr   <= '0;
            addr_sr  <= '0;
            mosi_sr  <= '0;
            miso_sr  <= '0;
            bit_cnt  <= '0;
            ovl      <= 1'b0;
        end else if (state != IDLE && sample) begin
            bit_cnt <= bit_cnt + {31'd0, ~&bit_cnt};
            fld_cnt <= last ? 16'd0 : fld_nx[15:0];
            if (state == CMD) cmd_sr <= {cmd_sr[30:0], mosi_s};
            if (state == ADDR) addr_sr <= {addr_sr[30:0], mosi_s};
            if (state == DATA) begin
                mosi_sr <= {mosi_sr[30:0], mosi_s};
                miso_sr <= {miso_sr[30:0], miso_s};
            end
            if (state == DONE) ovl <= 1'b1;
        end
    end

    // a finished frame replaces the held packet only if that packet is gone or leaving this cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv     <= 1'b0;
            p_len  <= '0;
            p_cmd  <= '0;
            p_addr <= '0;
            p_mosi <= '0;
            p_miso <= '0;
            p_flag <= '0;
            drops  <= '0;
        end else if (load && (!pv || bus.pkt_ready)) begin
            pv     <= 1'b1;
            p_len  <= bit_cnt;
            p_cmd  <= cmd_sr;
            p_addr <= addr_sr;
            p_mosi <= mosi_sr;
            p_miso <= miso_sr;
            p_flag <= {ovl, state != DONE};
        end else begin
            if (load) drops <= drops + {7'd0, ~&drops};
            if (pv && bus.pkt_ready) pv <= 1'b0;
        end
    end

    assign bus.pkt_valid      = pv;
    assign bus.pkt_spi_length = p_len;
    assign bus.pkt_cmd        = p_cmd;
    assign bus.pkt_addr       = p_addr;
    assign bus.pkt_mosi_data  = p_mosi;
    assign bus.pkt_miso_data  = p_miso;
    assign bus.pkt_flag       = p_flag;
    assign bus.drop_count     = drops;
endmodule

// File: tb/tb_spi_frame_collector.sv
// tb_spi_frame_collector: directed frame table plus backpressure, reset-abort and empty-frame sequences.
module tb_spi_frame_collector;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    spi_frame_collector_if bus();

    spi_frame_collector #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   cl;
        logic [5:0]   al;
        logic [15:0]  dl;
        int           n;
        logic [127:0] mo;
        logic [127:0] mi;
        logic [31:0]  e_len;
        logic [31:0]  e_cmd;
        logic [31:0]  e_addr;
        logic [31:0]  e_mosi;
        logic [31:0]  e_miso;
        logic [1:0]   e_flag;
    } vec_t;

    vec_t v[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sck_bits(input int n, input logic [127:0] mo, input logic [127:0] mi);
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi = mo[i];
            bus.spi_miso = mi[i];
            #40 bus.spi_sck = 1'b1;
            #40 bus.spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [5:0] cl, input logic [5:0] al, input logic [15:0] dl,
                         input int n, input logic [127:0] mo, input logic [127:0] mi);
        bus.cfg_cmd_len  = cl;
        bus.cfg_addr_len = al;
        bus.cfg_data_len = dl;
        bus.spi_csn = 1'b0;
        #50;
        sck_bits(n, mo, mi);
        #50 bus.spi_csn = 1'b1;
        #100;
    endtask

    task automatic wait_valid(input string nm, input bit exp);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = bus.pkt_valid;
        end
        chk(nm, {31'd0, seen}, {31'd0, exp});
    endtask

    task automatic handshake(input string nm);
        @(negedge clk) bus.pkt_ready = 1'b1;
        @(negedge clk) bus.pkt_ready = 1'b0;
        chk(nm, {31'd0, bus.pkt_valid}, 32'd0);
    endtask

    task automatic run_vec(input int k, input logic [7:0] exp_drop);
        frame(v[k].cl, v[k].al, v[k].dl, v[k].n, v[k].mo, v[k].mi);
        wait_valid($sformatf("v%0d valid", k), 1'b1);
        chk($sformatf("v%0d len", k), bus.pkt_spi_length, v[k].e_len);
        chk($sformatf("v%0d cmd", k), bus.pkt_cmd, v[k].e_cmd);
        chk($sformatf("v%0d addr", k), bus.pkt_addr, v[k].e_addr);
        chk($sformatf("v%0d mosi", k), bus.pkt_mosi_data, v[k].e_mosi);
        chk($sformatf("v%0d miso", k), bus.pkt_miso_data, v[k].e_miso);
        chk($sformatf("v%0d flag", k), {30'd0, bus.pkt_flag}, {30'd0, v[k].e_flag});
        chk($sformatf("v%0d drops", k), {24'd0, bus.drop_count}, {24'd0, exp_drop});
        handshake($sformatf("v%0d handshake", k));
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v[0] = '{6'd8, 6'd24, 16'd32, 64, 128'h0B001234DEADBEEF, 128'hCAFEF00D,
                 32'd64, 32'h0B, 32'h001234, 32'hDEADBEEF, 32'hCAFEF00D, 2'b00};
        v[1] = '{6'd8, 6'd0, 16'd0, 5, 128'h13, 128'h0,
                 32'd5, 32'h13, 32'h0, 32'h0, 32'h0, 2'b01};
        v[2] = '{6'd0, 6'd0, 16'd16, 20, 128'hABCDF, 128'h0,
                 32'd20, 32'h0, 32'h0, 32'hABCD, 32'h0, 2'b10};
        v[3] = '{6'd4, 6'd4, 16'd4, 12, 128'hA5C, 128'h00F,
                 32'd12, 32'hA, 32'h5, 32'hC, 32'hF, 2'b00};
        v[4] = '{6'd0, 6'd0, 16'd40, 40, 128'h123456789A, 128'hFF00000001,
                 32'd40, 32'h0, 32'h0, 32'h3456789A, 32'h00000001, 2'b00};
        v[5] = '{6'd40, 6'd0, 16'd0, 32, 128'h89ABCDEF, 128'h0,
                 32'd32, 32'h89ABCDEF, 32'h0, 32'h0, 32'h0, 2'b00};
        v[6] = '{6'd0, 6'd0, 16'd0, 3, 128'h7, 128'h0,
                 32'd3, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10};
        v[7] = '{6'd8, 6'd24, 16'd32, 12, 128'hB12, 128'h0,
                 32'd12, 32'hB1, 32'h2, 32'h0, 32'h0, 2'b01};

        bus.spi_csn = 1'b1;
        bus.spi_sck = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_miso = 1'b0;
        bus.pkt_ready = 1'b0;
        bus.cfg_cmd_len = 6'd8;
        bus.cfg_addr_len = 6'd24;
        bus.cfg_data_len = 16'd32;
        #3;
        repeat (3) @(negedge clk);
        chk("rst valid", {31'd0, bus.pkt_valid}, 32'd0);
        chk("rst len", bus.pkt_spi_length, 32'd0);
        chk("rst cmd", bus.pkt_cmd, 32'd0);
        chk("rst mosi", bus.pkt_mosi_data, 32'd0);
        chk("rst flag", {30'd0, bus.pkt_flag}, 32'd0);
        chk("rst drops", {24'd0, bus.drop_count}, 32'd0);
        rstn = 1'b1;
        #100;

        for (int k = 0; k < 8; k++) run_vec(k, 8'd0);

        // csn pulse with no sck edges produces nothing
        bus.spi_csn = 1'b0;
        #100 bus.spi_csn = 1'b1;
        #100;
        wait_valid("empty valid", 1'b0);
        chk("empty drops", {24'd0, bus.drop_count}, 32'd0);

        // backpressure across three frames keeps the first packet
        frame(v[3].cl, v[3].al, v[3].dl, v[3].n, v[3].mo, v[3].mi);
        frame(v[1].cl, v[1].al, v[1].dl, v[1].n, v[1].mo, v[1].mi);
        frame(v[7].cl, v[7].al, v[7].dl, v[7].n, v[7].mo, v[7].mi);
        @(negedge clk);
        chk("bp valid", {31'd0, bus.pkt_valid}, 32'd1);
        chk("bp cmd", bus.pkt_cmd, 32'hA);
        chk("bp len", bus.pkt_spi_length, 32'd12);
        chk("bp flag", {30'd0, bus.pkt_flag}, 32'd0);
        chk("bp drops", {24'd0, bus.drop_count}, 32'd2);
        handshake("bp handshake");
        wait_valid("bp no stale", 1'b0);

        // reset mid-DATA with csn held low, then a clean frame
        bus.cfg_cmd_len = 6'd8;
        bus.cfg_addr_len = 6'd24;
        bus.cfg_data_len = 16'd32;
        bus.spi_csn = 1'b0;
        #50;
        sck_bits(45, 128'h0B001234DEA, 128'h0);
        @(negedge clk) rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort rst valid", {31'd0, bus.pkt_valid}, 32'd0);
        chk("abort rst drops", {24'd0, bus.drop_count}, 32'd0);
        rstn = 1'b1;
        sck_bits(10, 128'h3FF, 128'h0);
        #50 bus.spi_csn = 1'b1;
        #100;
        wait_valid("abort no pkt", 1'b0);
        run_vec(0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
